// File: rtl/fw_sram_wishbone_bridge_pkg.sv
// -----------------------------------------------------------------------------
// fw_sram_wishbone_bridge_pkg
// Shared definitions for the generic-SRAM-target to Wishbone-initiator bridge:
// the FSM state encoding, default widths, the Wishbone tag width and small
// helpers for deriving byte-lane counts and timeout counter widths.
// No ports (package).
// -----------------------------------------------------------------------------
package fw_sram_wishbone_bridge_pkg;

  // Bridge FSM: one request in flight at most, so two states are enough.
  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } bridge_state_t;

  localparam int DEFAULT_ADR_WIDTH = 32;
  localparam int DEFAULT_DAT_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT   = 256;

  // Cycle tag is always driven zero, meaning non-atomic access.
  localparam int TGC_WIDTH = 4;

  // Number of byte lanes carried by a data word.
  function automatic int laneCount(input int datWidth);
    return datWidth / 8;
  endfunction

  // Counter width able to hold 0 .. timeout-1, never narrower than one bit.
  function automatic int counterWidth(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/fw_sram_wishbone_bridge_if.sv
// -----------------------------------------------------------------------------
// fw_sram_wishbone_bridge_if
// Two interfaces used by the bridge:
//   fw_sram_if : generic byte-enable SRAM port plus busy/error extensions.
//                master = requester (CPU/DMA), slave = bridge.
//   fw_wb_if   : Wishbone classic single-cycle initiator signals.
//                master = bridge (initiator), slave = Wishbone target.
// -----------------------------------------------------------------------------
interface fw_sram_if
  import fw_sram_wishbone_bridge_pkg::*;
#(
  parameter int ADR_WIDTH = DEFAULT_ADR_WIDTH,
  parameter int DAT_WIDTH = DEFAULT_DAT_WIDTH
) ();

  logic [ADR_WIDTH-1:0]            t_addr;
  logic                            t_read_en;
  logic                            t_write_en;
  logic [DAT_WIDTH-1:0]            t_write_data;
  logic [laneCount(DAT_WIDTH)-1:0] t_byte_en;
  logic [DAT_WIDTH-1:0]            t_read_data;
  logic                            t_busy;
  logic                            t_err;
  logic                            t_err_clr;

  modport master (
    output t_addr, t_read_en, t_write_en, t_write_data, t_byte_en, t_err_clr,
    input  t_read_data, t_busy, t_err
  );

  modport slave (
    input  t_addr, t_read_en, t_write_en, t_write_data, t_byte_en, t_err_clr,
    output t_read_data, t_busy, t_err
  );

endinterface

interface fw_wb_if
  import fw_sram_wishbone_bridge_pkg::*;
#(
  parameter int ADR_WIDTH = DEFAULT_ADR_WIDTH,
  parameter int DAT_WIDTH = DEFAULT_DAT_WIDTH
) ();

  logic [ADR_WIDTH-1:0]            i_adr;
  logic [DAT_WIDTH-1:0]            i_dat_w;
  logic [DAT_WIDTH-1:0]            i_dat_r;
  logic [laneCount(DAT_WIDTH)-1:0] i_sel;
  logic                            i_we;
  logic                            i_cyc;
  logic                            i_stb;
  logic                            i_ack;
  logic                            i_err;
  logic [TGC_WIDTH-1:0]            i_tgc;
  logic                            i_tga;
  logic                            i_tgd_w;
  logic                            i_tgd_r;

  modport master (
    output i_adr, i_dat_w, i_sel, i_we, i_cyc, i_stb, i_tgc, i_tga, i_tgd_w,
    input  i_dat_r, i_ack, i_err, i_tgd_r
  );

  modport slave (
    input  i_adr, i_dat_w, i_sel, i_we, i_cyc, i_stb, i_tgc, i_tga, i_tgd_w,
    output i_dat_r, i_ack, i_err, i_tgd_r
  );

endinterface

// File: rtl/fw_sram_wishbone_bridge_timeout.sv
// -----------------------------------------------------------------------------
// fw_wb_timeout_counter
// Bus-cycle watchdog shared by Wishbone initiators. Counts cycles while
// enabled and flags expiry in the TIMEOUT-th counted cycle. TIMEOUT = 0
// disables the watchdog entirely (expired never asserts).
// Ports:
//   clock     in  posedge clock
//   reset     in  asynchronous active-high reset
//   i_clear   in  force the count back to zero (has priority over enable)
//   i_enable  in  count this cycle
//   o_expired out high in the cycle whose count equals TIMEOUT-1
// -----------------------------------------------------------------------------
module fw_wb_timeout_counter
  import fw_sram_wishbone_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  if (TIMEOUT == 0) begin : g_disabled

    // Watchdog compiled out: inputs are intentionally left without effect.
    logic w_unused;
    assign w_unused  = ^{i_clear, i_enable, clock, reset};
    assign o_expired = 1'b0;

  end else begin : g_enabled

    localparam int CNT_W = counterWidth(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, saturating at LAST so a caller that keeps the
    // counter enabled past expiry never sees the count wrap.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_count <= '0;
      end else if (i_clear) begin
        r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
        r_count <= r_count + 1'b1;
      end
    end

    assign o_expired = i_enable && (r_count == LAST);

  end

endmodule

// File: rtl/fw_sram_wishbone_bridge.sv
// -----------------------------------------------------------------------------
// fw_sram_wishbone_bridge
// Generic-SRAM-target to Wishbone-initiator bridge. Each SRAM request is
// registered and issued as one Wishbone classic single cycle; the requester
// is stalled with t_busy until the cycle terminates.
// Ports:
//   clock  in   single clock, posedge
//   reset  in   asynchronous active-high reset
//   sram   fw_sram_if.slave  : t_addr/t_read_en/t_write_en/t_write_data/
//          t_byte_en/t_err_clr in; t_read_data/t_busy/t_err out
//   wb     fw_wb_if.master   : i_adr/i_dat_w/i_sel/i_we/i_cyc/i_stb and tags
//          out; i_dat_r/i_ack/i_err/i_tgd_r in
// Parameters: ADR_WIDTH, DAT_WIDTH, TIMEOUT (0 disables the bus watchdog).
// -----------------------------------------------------------------------------
module fw_sram_wishbone_bridge
  import fw_sram_wishbone_bridge_pkg::*;
#(
  parameter int ADR_WIDTH = DEFAULT_ADR_WIDTH,
  parameter int DAT_WIDTH = DEFAULT_DAT_WIDTH,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic     clock,
  input  logic     reset,
  fw_sram_if.slave sram,
  fw_wb_if.master  wb
);

  localparam int LANES = laneCount(DAT_WIDTH);

  bridge_state_t r_state;
  bridge_state_t w_nextState;

  logic [ADR_WIDTH-1:0] r_adr;
  logic [DAT_WIDTH-1:0] r_datW;
  logic [LANES-1:0]     r_sel;
  logic                 r_we;
  logic [DAT_WIDTH-1:0] r_readData;
  logic                 r_err;

  logic w_capture;
  logic w_ackDone;
  logic w_fail;
  logic w_inBus;
  logic w_expired;
  logic w_unused;

  assign w_inBus = (r_state == BUS);

  // Watchdog is held cleared outside BUS so it starts from zero on every
  // new cycle and counts each cycle the bus is held.
  fw_wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!w_inBus),
    .i_enable  (w_inBus),
    .o_expired (w_expired)
  );

  // State register. Async reset abandons any in-flight cycle immediately,
  // which drops cyc/stb in the same cycle the reset arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and event decode. In BUS the termination priority is
  // err, then ack, then watchdog expiry; a real termination in the expiry
  // cycle therefore wins over the timeout.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_ackDone   = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      IDLE: begin
        if (sram.t_read_en || sram.t_write_en) begin
          w_capture   = 1'b1;
          w_nextState = BUS;
        end
      end
      BUS: begin
        if (wb.i_err) begin
          w_fail      = 1'b1;
          w_nextState = IDLE;
        end else if (wb.i_ack) begin
          w_ackDone   = 1'b1;
          w_nextState = IDLE;
        end else if (w_expired) begin
          w_fail      = 1'b1;
          w_nextState = IDLE;
        end
      end
    endcase
  end

  // Request capture. Only sampled in IDLE, so anything the requester
  // presents while busy is ignored until the bridge is free again.
  // A write request wins when read and write are both asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_adr  <= '0;
      r_datW <= '0;
      r_sel  <= '0;
      r_we   <= 1'b0;
    end else if (w_capture) begin
      r_adr  <= sram.t_addr;
      r_datW <= sram.t_write_data;
      r_sel  <= sram.t_byte_en;
      r_we   <= sram.t_write_en;
    end
  end

  // Read data holds the last completed read. A failed read (bus error or
  // timeout) replaces it with zero; writes never touch it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_readData <= '0;
    end else if (w_ackDone && !r_we) begin
      r_readData <= wb.i_dat_r;
    end else if (w_fail && !r_we) begin
      r_readData <= '0;
    end
  end

  // Sticky error flag. Setting has priority over a clear in the same cycle
  // so a failure is never lost to a concurrent software clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_fail) begin
      r_err <= 1'b1;
    end else if (sram.t_err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Wishbone drive. Write enable and byte selects are qualified with the
  // cycle so they are only asserted while cyc is high.
  assign wb.i_adr   = r_adr;
  assign wb.i_dat_w = r_datW;
  assign wb.i_sel   = w_inBus ? r_sel : '0;
  assign wb.i_we    = w_inBus && r_we;
  assign wb.i_cyc   = w_inBus;
  assign wb.i_stb   = w_inBus;
  assign wb.i_tgc   = '0;
  assign wb.i_tga   = 1'b0;
  assign wb.i_tgd_w = 1'b0;

  // Incoming data tag carries nothing this bridge uses.
  assign w_unused = wb.i_tgd_r;

  assign sram.t_read_data = r_readData;
  assign sram.t_busy      = w_inBus;
  assign sram.t_err       = r_err;

endmodule

// File: tb/tb_fw_sram_wishbone_bridge.sv
// -----------------------------------------------------------------------------
// tb_fw_sram_wishbone_bridge
// Directed bench for the SRAM-to-Wishbone bridge. dutA uses TIMEOUT=8 for
// the main sequence; dutB uses TIMEOUT=0 and is only checked for holding a
// never-acknowledged cycle.
// -----------------------------------------------------------------------------
module tb_fw_sram_wishbone_bridge;

  logic clock;
  logic reset;

  int testCount;
  int failCount;
  int cycHigh;

  fw_sram_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) sramA ();
  fw_wb_if   #(.ADR_WIDTH(32), .DAT_WIDTH(32)) wbA ();
  fw_sram_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) sramB ();
  fw_wb_if   #(.ADR_WIDTH(32), .DAT_WIDTH(32)) wbB ();

  fw_sram_wishbone_bridge #(
    .ADR_WIDTH (32),
    .DAT_WIDTH (32),
    .TIMEOUT   (8)
  ) dutA (
    .clock (clock),
    .reset (reset),
    .sram  (sramA),
    .wb    (wbA)
  );

  fw_sram_wishbone_bridge #(
    .ADR_WIDTH (32),
    .DAT_WIDTH (32),
    .TIMEOUT   (0)
  ) dutB (
    .clock (clock),
    .reset (reset),
    .sram  (sramB),
    .wb    (wbB)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; inputs driven and outputs sampled 1 unit after posedge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an SRAM request on dutA.
  task automatic applyStimulus(input logic re, input logic we,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
    sramA.t_read_en    = re;
    sramA.t_write_en   = we;
    sramA.t_addr       = addr;
    sramA.t_write_data = data;
    sramA.t_byte_en    = be;
  endtask

  // One comparison against a hand-computed expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Target response on dutA's Wishbone side.
  task automatic targetResp(input logic ack, input logic err, input logic [31:0] data);
    wbA.i_ack   = ack;
    wbA.i_err   = err;
    wbA.i_dat_r = data;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sramA.t_err_clr = 1'b0;
    targetResp(1'b0, 1'b0, 32'h0);
    wbA.i_tgd_r = 1'b0;
    sramB.t_read_en = 1'b0; sramB.t_write_en = 1'b0; sramB.t_addr = 32'h0;
    sramB.t_write_data = 32'h0; sramB.t_byte_en = 4'h0; sramB.t_err_clr = 1'b0;
    wbB.i_ack = 1'b0; wbB.i_err = 1'b0; wbB.i_dat_r = 32'h0; wbB.i_tgd_r = 1'b0;

    // Reset state
    tick(); tick();
    checkOutput("rst_cyc",  {31'b0, wbA.i_cyc},  32'h0);
    checkOutput("rst_busy", {31'b0, sramA.t_busy}, 32'h0);
    checkOutput("rst_err",  {31'b0, sramA.t_err},  32'h0);
    checkOutput("rst_rdata", sramA.t_read_data,  32'h0);
    checkOutput("rst_adr",  wbA.i_adr, 32'h0);
    reset = 1'b0;
    tick();

    // Zero-wait write
    applyStimulus(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("wr_cyc",  {31'b0, wbA.i_cyc}, 32'h1);
    checkOutput("wr_we",   {31'b0, wbA.i_we},  32'h1);
    checkOutput("wr_sel",  {28'b0, wbA.i_sel}, 32'hF);
    checkOutput("wr_adr",  wbA.i_adr,   32'h100);
    checkOutput("wr_dat",  wbA.i_dat_w, 32'hDEADBEEF);
    checkOutput("wr_busy", {31'b0, sramA.t_busy}, 32'h1);
    targetResp(1'b1, 1'b0, 32'h0);
    tick();
    targetResp(1'b0, 1'b0, 32'h0);
    checkOutput("wr_done_busy", {31'b0, sramA.t_busy}, 32'h0);
    checkOutput("wr_done_we",   {31'b0, wbA.i_we},  32'h0);
    checkOutput("wr_done_sel",  {28'b0, wbA.i_sel}, 32'h0);
    checkOutput("wr_rdata",     sramA.t_read_data, 32'h0);

    // Read with three wait states
    applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycHigh = 0;
    for (int i = 0; i < 3; i++) begin
      if (wbA.i_cyc) cycHigh++;
      tick();
    end
    targetResp(1'b1, 1'b0, 32'h12345678);
    checkOutput("rd_we", {31'b0, wbA.i_we}, 32'h0);
    if (wbA.i_cyc) cycHigh++;
    tick();
    targetResp(1'b0, 1'b0, 32'hFFFFFFFF);
    checkOutput("rd_cyc_cycles", cycHigh, 32'd4);
    checkOutput("rd_cyc_low", {31'b0, wbA.i_cyc}, 32'h0);
    checkOutput("rd_data", sramA.t_read_data, 32'h12345678);

    // Following write must leave read data alone
    applyStimulus(1'b0, 1'b1, 32'h300, 32'hA5A5A5A5, 4'h3);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("wr2_sel", {28'b0, wbA.i_sel}, 32'h3);
    targetResp(1'b1, 1'b0, 32'h0);
    tick();
    targetResp(1'b0, 1'b0, 32'h0);
    checkOutput("wr2_rdata_held", sramA.t_read_data, 32'h12345678);

    // Read and write together: write wins
    applyStimulus(1'b1, 1'b1, 32'h400, 32'h0BADF00D, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("both_we",  {31'b0, wbA.i_we}, 32'h1);
    checkOutput("both_dat", wbA.i_dat_w, 32'h0BADF00D);
    targetResp(1'b1, 1'b0, 32'h55555555);
    tick();
    targetResp(1'b0, 1'b0, 32'h0);
    checkOutput("both_rdata_held", sramA.t_read_data, 32'h12345678);

    // Bus error on a read, err asserted together with ack
    applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    targetResp(1'b1, 1'b1, 32'h77777777);
    tick();
    targetResp(1'b0, 1'b0, 32'h0);
    checkOutput("err_flag",  {31'b0, sramA.t_err}, 32'h1);
    checkOutput("err_rdata", sramA.t_read_data, 32'h0);
    checkOutput("err_busy",  {31'b0, sramA.t_busy}, 32'h0);
    sramA.t_err_clr = 1'b1;
    tick();
    sramA.t_err_clr = 1'b0;
    checkOutput("err_clr", {31'b0, sramA.t_err}, 32'h0);

    // Zero-wait read: data valid two cycles after the request edge
    applyStimulus(1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    targetResp(1'b1, 1'b0, 32'hCAFEF00D);
    tick();
    targetResp(1'b0, 1'b0, 32'h0);
    checkOutput("rd0_data", sramA.t_read_data, 32'hCAFEF00D);
    checkOutput("rd0_busy", {31'b0, sramA.t_busy}, 32'h0);

    // Timeout: never terminated, must drop after exactly 8 BUS cycles
    applyStimulus(1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cycHigh = 0;
    while (wbA.i_cyc && cycHigh < 20) begin
      cycHigh++;
      tick();
    end
    checkOutput("to_cycles", cycHigh, 32'd8);
    checkOutput("to_err",    {31'b0, sramA.t_err}, 32'h1);
    checkOutput("to_rdata",  sramA.t_read_data, 32'h0);

    // Reset in the middle of a bus cycle
    applyStimulus(1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("mid_cyc_pre", {31'b0, wbA.i_cyc}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mid_cyc",  {31'b0, wbA.i_cyc},   32'h0);
    checkOutput("mid_busy", {31'b0, sramA.t_busy}, 32'h0);
    checkOutput("mid_err",  {31'b0, sramA.t_err},  32'h0);
    #1;
    reset = 1'b0;
    tick();

    // Request held across busy: the second one waits for IDLE
    applyStimulus(1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b1, 32'hA00, 32'h13572468, 4'hC);
    checkOutput("hold_adr1", wbA.i_adr, 32'h900);
    tick();
    checkOutput("hold_adr2", wbA.i_adr, 32'h900);
    checkOutput("hold_we",   {31'b0, wbA.i_we}, 32'h0);
    targetResp(1'b1, 1'b0, 32'h11112222);
    tick();
    targetResp(1'b0, 1'b0, 32'h0);
    checkOutput("hold_rdata", sramA.t_read_data, 32'h11112222);
    checkOutput("hold_idle",  {31'b0, sramA.t_busy}, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("hold2_cyc", {31'b0, wbA.i_cyc}, 32'h1);
    checkOutput("hold2_adr", wbA.i_adr, 32'hA00);
    checkOutput("hold2_we",  {31'b0, wbA.i_we}, 32'h1);
    checkOutput("hold2_sel", {28'b0, wbA.i_sel}, 32'hC);
    targetResp(1'b1, 1'b0, 32'h0);
    tick();
    targetResp(1'b0, 1'b0, 32'h0);
    checkOutput("hold2_rdata", sramA.t_read_data, 32'h11112222);

    // TIMEOUT=0 instance keeps an unanswered cycle open indefinitely
    sramB.t_read_en = 1'b1;
    sramB.t_addr    = 32'hB00;
    tick();
    sramB.t_read_en = 1'b0;
    repeat (1000) tick();
    checkOutput("nt_cyc",  {31'b0, wbB.i_cyc},    32'h1);
    checkOutput("nt_busy", {31'b0, sramB.t_busy}, 32'h1);
    checkOutput("nt_err",  {31'b0, sramB.t_err},  32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fw_sram_wishbone_bridge.md
# fw_sram_wishbone_bridge

Generic-SRAM-target to Wishbone-initiator bridge: the opposite direction of the team's Wishbone-to-SRAM controller. A block written against the generic byte-enable SRAM port (CPU-local memory port, DMA engine) issues single Wishbone classic cycles through this bridge to reach any Wishbone target. A `t_busy` stall output is added to the SRAM port, a bus timeout is programmable, and one request is registered at a time.

## Interface
Parameters:
- ADR_WIDTH, 32, address width, both sides
- DAT_WIDTH, 32, data width, both sides; byte lanes = DAT_WIDTH/8
- TIMEOUT, 256, cycles allowed in BUS before abort; 0 disables the timeout

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- t_addr  in  ADR_WIDTH  SRAM request address
- t_read_en  in  1  read request
- t_write_en  in  1  write request; wins if asserted with t_read_en
- t_write_data  in  DAT_WIDTH  write data
- t_byte_en  in  DAT_WIDTH/8  byte lanes
- t_read_data  out  DAT_WIDTH  last completed read data; reset 0
- t_busy  out  1  request in flight; new requests ignored while high; reset 0
- t_err  out  1  sticky error flag; reset 0
- t_err_clr  in  1  clears t_err
- i_adr  out  ADR_WIDTH  Wishbone address; reset 0
- i_dat_w  out  DAT_WIDTH  write data; reset 0
- i_dat_r  in  DAT_WIDTH  read data
- i_sel  out  DAT_WIDTH/8  byte select; reset 0
- i_we  out  1  write enable; reset 0
- i_cyc, i_stb  out  1  cycle/strobe, identical; reset 0
- i_ack, i_err  in  1  termination
- i_tgc  out  4  tied 0 (non-atomic); i_tga, i_tgd_w  out  1  tied 0; i_tgd_r  in  1  ignored

## Operation
- States: IDLE, BUS.
- IDLE: t_busy=0, i_cyc=i_stb=0. When t_read_en|t_write_en: capture t_addr, t_write_data, t_byte_en, we=t_write_en into registers; go to BUS.
- BUS: i_cyc=i_stb=1, outputs driven from captured registers, stable for the whole cycle; t_busy=1.
  - i_ack: on a read, register i_dat_r into t_read_data; go to IDLE.
  - i_err (with or without i_ack): set t_err; on a read, t_read_data <= 0; go to IDLE. i_err takes priority over i_ack.
  - Timeout: counter cleared on entering BUS and incremented each BUS cycle. When it reaches TIMEOUT-1 with no termination: set t_err, read data <= 0, go to IDLE. A termination in that same cycle wins over the timeout.
- t_read_data is held until the next read completes. Writes leave it unchanged.
- t_err_clr clears t_err. A set in the same cycle wins.
- Requests presented while t_busy=1 are not captured. The requester holds the request until busy drops.

## Timing
- Request sampled in IDLE at edge N. i_cyc/i_stb are high from N+1.
- Zero-wait ack in cycle N+1 → IDLE at N+2. t_busy is low and t_read_data is valid from N+2. The minimum round trip is 2 cycles.
- t_busy is registered, asserted in the cycle after the request is sampled. A back-to-back request is therefore accepted at N+2 at the earliest.
- At most one outstanding cycle. No pipelining, no bursts.
- Reset asserted mid-BUS immediately drops i_cyc/i_stb (async) and returns the bridge to IDLE. The in-flight request is lost, and t_err is cleared.

## Structure
- Shared include (alongside the existing Wishbone/SRAM macro headers): state encodings IDLE=1'b0, BUS=1'b1 as localparams. The port lists reuse the existing Wishbone initiator-tag and generic-SRAM-target port macros; `t_busy`, `t_err` and `t_err_clr` are added explicitly.
- One sub-module is natural: `fw_wb_timeout_counter`, parameterised by TIMEOUT, with inputs clear/enable and output expired. It is reused later by other initiators.

## Test plan
- Write: addr 0x100, data 0xDEADBEEF, byte_en 0xF, target acks in first BUS cycle → i_we=1, i_sel=0xF for exactly 1 cycle; busy low 2 cycles after request.
- Read with 3 wait states: target returns 0x12345678 → i_cyc high 4 cycles; t_read_data=0x12345678 after IDLE and held through a following write.
- Simultaneous t_read_en=t_write_en=1 → Wishbone write issued, t_read_data unchanged.
- Target asserts i_err on a read → t_err=1, t_read_data=0. t_err_clr pulse → t_err=0.
- TIMEOUT=8, target never acks → cyc dropped after exactly 8 BUS cycles, t_err=1. With TIMEOUT=0, cyc is still held after 1000 cycles.
- Reset asserted during BUS → i_cyc=0 in the same cycle, t_busy=0. A request held during busy is accepted only once busy is low.
